// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared bus widths, exception codes, boot vector and FSM encodings
`ifndef PIPELINE_CTRL_BUS_DEFS
`define PIPELINE_CTRL_BUS_DEFS
`define EXC_TYPE_BUS_WIDTH 5
`define ADDR_BUS_WIDTH     32
`define EXC_NONE           5'h00
`define EXC_INT            5'h01
`define EXC_ADEL           5'h04
`define EXC_ADES           5'h05
`define EXC_SYS            5'h08
`define EXC_BP             5'h09
`define EXC_RI             5'h0a
`define EXC_OV             5'h0c
`define EXC_ERET           5'h0e
`define EXC_ENTRY_PC       32'hBFC00380
`define PCTRL_ST_IDLE      2'd0
`define PCTRL_ST_PEND      2'd1
`define PCTRL_ST_FLUSH     2'd2
`define PCTRL_ST_HOLD      2'd3
`endif

package pipeline_ctrl_pkg;
   localparam int EXC_W  = `EXC_TYPE_BUS_WIDTH;
   localparam int ADDR_W = `ADDR_BUS_WIDTH;

   localparam logic [EXC_W-1:0]  EXC_NONE = `EXC_NONE;
   localparam logic [EXC_W-1:0]  EXC_ERET = `EXC_ERET;
   localparam logic [ADDR_W-1:0] ENTRY_PC = `EXC_ENTRY_PC;

   localparam logic [1:0] ST_IDLE  = `PCTRL_ST_IDLE;
   localparam logic [1:0] ST_PEND  = `PCTRL_ST_PEND;
   localparam logic [1:0] ST_FLUSH = `PCTRL_ST_FLUSH;
   localparam logic [1:0] ST_HOLD  = `PCTRL_ST_HOLD;

   typedef struct packed {
      logic pc;
      logic if_s;
      logic id;
      logic ex;
      logic mem;
      logic wb;
   } stall_vec_t;
endpackage

// File: rtl/stall_encoder.sv
// rtl/stall_encoder.sv - combinational stall priority: the deepest requesting stage holds itself and everything upstream
module stall_encoder
   import pipeline_ctrl_pkg::*;
(
   input  logic       stall_req_if_i,
   input  logic       stall_req_id_i,
   input  logic       stall_req_ex_i,
   input  logic       stall_req_mem_i,
   output stall_vec_t stall_o
);
   assign stall_o.mem  = stall_req_mem_i;
   assign stall_o.ex   = stall_req_mem_i | stall_req_ex_i;
   assign stall_o.id   = stall_req_mem_i | stall_req_ex_i | stall_req_id_i;
   assign stall_o.if_s = stall_req_mem_i | stall_req_ex_i | stall_req_id_i | stall_req_if_i;
   assign stall_o.pc   = stall_o.if_s;
   assign stall_o.wb   = 1'b0;
endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush controller with exception redirect FSM and stall-cycle counter
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_req_if,
   input  logic              stall_req_id,
   input  logic              stall_req_ex,
   input  logic              stall_req_mem,
   input  logic [EXC_W-1:0]  exc_type_in,
   input  logic [ADDR_W-1:0] cp0_epc_in,
   output logic              stall_pc,
   output logic              stall_if,
   output logic              stall_id,
   output logic              stall_ex,
   output logic              stall_mem,
   output logic              stall_wb,
   output logic              flush,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [31:0]       stall_cycle_cnt
);
   logic [1:0]        state_q, state_d;
   logic [EXC_W-1:0]  exc_q, exc_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic [31:0]       cnt_q;
   stall_vec_t        req_stall;
   stall_vec_t        stall;
   logic              in_flush;

   stall_encoder u_stall_encoder (
      .stall_req_if_i  (stall_req_if),
      .stall_req_id_i  (stall_req_id),
      .stall_req_ex_i  (stall_req_ex),
      .stall_req_mem_i (stall_req_mem),
      .stall_o         (req_stall)
   );

   assign in_flush = (state_q == ST_FLUSH);
   // The flush cycle wipes every pipeline register, so no stage may hold.
   assign stall    = in_flush ? '0 : req_stall;

   assign stall_pc  = stall.pc;
   assign stall_if  = stall.if_s;
   assign stall_id  = stall.id;
   assign stall_ex  = stall.ex;
   assign stall_mem = stall.mem;
   assign stall_wb  = stall.wb;

   assign flush           = in_flush;
   assign redirect_valid  = in_flush;
   assign redirect_pc     = !in_flush              ? '0    :
                            (exc_q == EXC_ERET)    ? epc_q : ENTRY_PC;
   assign stall_cycle_cnt = cnt_q;

   always_comb begin
      state_d = state_q;
      exc_d   = exc_q;
      epc_d   = epc_q;
      case (state_q)
         ST_IDLE: begin
            if (exc_type_in != EXC_NONE) begin
               exc_d   = exc_type_in;
               epc_d   = cp0_epc_in;
               state_d = stall_req_mem ? ST_PEND : ST_FLUSH;
            end
         end
         ST_PEND:  if (!stall_req_mem) state_d = ST_FLUSH;
         ST_FLUSH: state_d = ST_HOLD;
         // HOLD ignores the stale code still sitting in the flushed MEM register.
         ST_HOLD:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         exc_q   <= '0;
         epc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         exc_q   <= exc_d;
         epc_q   <= epc_d;
         if (stall.pc) cnt_q <= cnt_q + 32'd1;
      end
   end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed-vector scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;
   localparam logic [4:0]  X_NONE = 5'h00;
   localparam logic [4:0]  X_SYS  = 5'h08;
   localparam logic [4:0]  X_OV   = 5'h0c;
   localparam logic [4:0]  X_ERET = 5'h0e;
   localparam logic [31:0] BOOT   = 32'hBFC00380;

   typedef struct {
      int          id;
      logic [5:0]  stall;
      logic        flush;
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_if = 1'b0, req_id = 1'b0, req_ex = 1'b0, req_mem = 1'b0;
   logic [4:0]  exc = 5'h00;
   logic [31:0] epc = 32'h0;
   logic        s_pc, s_if, s_id, s_ex, s_mem, s_wb, flush, rv;
   logic [31:0] rpc, cnt;

   exp_t q[$];
   int   vectors = 0;
   int   errors  = 0;
   int   issued  = 0;

   pipeline_ctrl dut (
      .clk(clk), .rst(rst),
      .stall_req_if(req_if), .stall_req_id(req_id),
      .stall_req_ex(req_ex), .stall_req_mem(req_mem),
      .exc_type_in(exc), .cp0_epc_in(epc),
      .stall_pc(s_pc), .stall_if(s_if), .stall_id(s_id),
      .stall_ex(s_ex), .stall_mem(s_mem), .stall_wb(s_wb),
      .flush(flush), .redirect_valid(rv), .redirect_pc(rpc),
      .stall_cycle_cnt(cnt)
   );

   always #5 clk = ~clk;

   // req is {mem, ex, id, if}; est is {pc, if, id, ex, mem, wb}
   task automatic vec(input logic r, input logic [3:0] req, input logic [4:0] x,
                      input logic [31:0] e, input logic [5:0] est, input logic ef,
                      input logic erv, input logic [31:0] erpc, input logic [31:0] ecnt);
      exp_t t;
      @(posedge clk);
      #1;
      rst = r;
      {req_mem, req_ex, req_id, req_if} = req;
      exc = x;
      epc = e;
      t.id = issued; t.stall = est; t.flush = ef; t.rv = erv; t.rpc = erpc; t.cnt = ecnt;
      q.push_back(t);
      issued++;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t t;
         t = q.pop_front();
         vectors++;
         if ({s_pc, s_if, s_id, s_ex, s_mem, s_wb} !== t.stall) begin
            errors++;
            $display("FAIL v%0d stall: got %b want %b", t.id, {s_pc, s_if, s_id, s_ex, s_mem, s_wb}, t.stall);
         end
         if (flush !== t.flush) begin
            errors++;
            $display("FAIL v%0d flush: got %b want %b", t.id, flush, t.flush);
         end
         if (rv !== t.rv) begin
            errors++;
            $display("FAIL v%0d redirect_valid: got %b want %b", t.id, rv, t.rv);
         end
         if (rpc !== t.rpc) begin
            errors++;
            $display("FAIL v%0d redirect_pc: got %h want %h", t.id, rpc, t.rpc);
         end
         if (cnt !== t.cnt) begin
            errors++;
            $display("FAIL v%0d stall_cycle_cnt: got %0d want %0d", t.id, cnt, t.cnt);
         end
      end
   end

   initial begin
      // reset: outputs cleared, stalls still follow requests
      vec(0, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 0);
      vec(0, 4'b0011, X_NONE, 0, 6'b111000, 0, 0, 0, 0);
      // stall priority and counting
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 0);
      vec(1, 4'b0011, X_NONE, 0, 6'b111000, 0, 0, 0, 0);
      vec(1, 4'b0011, X_NONE, 0, 6'b111000, 0, 0, 0, 1);
      vec(1, 4'b0001, X_NONE, 0, 6'b110000, 0, 0, 0, 2);
      vec(1, 4'b0100, X_NONE, 0, 6'b111100, 0, 0, 0, 3);
      vec(1, 4'b1000, X_NONE, 0, 6'b111110, 0, 0, 0, 4);
      vec(1, 4'b1111, X_NONE, 0, 6'b111110, 0, 0, 0, 5);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 6);
      // syscall, no stall: flush one cycle later
      vec(1, 4'b0000, X_SYS,  0, 6'b000000, 0, 0, 0, 6);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 1, 1, BOOT, 6);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 6);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 6);
      // ERET redirects to latched EPC
      vec(1, 4'b0000, X_ERET, 32'h80001234, 6'b000000, 0, 0, 0, 6);
      vec(1, 4'b0000, X_NONE, 32'h0, 6'b000000, 1, 1, 32'h80001234, 6);
      vec(1, 4'b0000, X_NONE, 32'h0, 6'b000000, 0, 0, 0, 6);
      // flush overrides stalls, not counted; HOLD ignores stale code
      vec(1, 4'b0010, X_SYS,  0, 6'b111000, 0, 0, 0, 6);
      vec(1, 4'b1111, X_NONE, 0, 6'b000000, 1, 1, BOOT, 7);
      vec(1, 4'b0001, X_SYS,  0, 6'b110000, 0, 0, 0, 7);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 8);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 8);
      // exception during dcache miss: waits, then uses cycle-1 code/EPC
      vec(1, 4'b1000, X_OV,   32'hAAAA0000, 6'b111110, 0, 0, 0, 8);
      vec(1, 4'b1000, X_NONE, 32'h00005555, 6'b111110, 0, 0, 0, 9);
      vec(1, 4'b1000, X_NONE, 32'h00005555, 6'b111110, 0, 0, 0, 10);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 11);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 1, 1, BOOT, 11);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 11);
      // ERET latched in PEND keeps its EPC despite input change
      vec(1, 4'b1000, X_ERET, 32'h80004000, 6'b111110, 0, 0, 0, 11);
      vec(1, 4'b0000, X_NONE, 32'h12345678, 6'b000000, 0, 0, 0, 12);
      vec(1, 4'b0000, X_NONE, 32'h12345678, 6'b000000, 1, 1, 32'h80004000, 12);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 12);
      // code held two cycles gives a single flush
      vec(1, 4'b0000, X_SYS,  0, 6'b000000, 0, 0, 0, 12);
      vec(1, 4'b0000, X_SYS,  0, 6'b000000, 1, 1, BOOT, 12);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 12);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 12);
      // reset in PEND abandons the exception
      vec(1, 4'b1000, X_SYS,  0, 6'b111110, 0, 0, 0, 12);
      vec(1, 4'b1000, X_NONE, 0, 6'b111110, 0, 0, 0, 13);
      vec(0, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 0);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 0);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 0);
      vec(1, 4'b0000, X_NONE, 0, 6'b000000, 0, 0, 0, 0);
      for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected vectors never checked (want 0)", q.size());
      end
      if (vectors != issued) begin
         errors++;
         $display("FAIL count: checked %0d vectors, want %0d", vectors, issued);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
